riscmakers_dcache_port_arbiter: RTL and testbench
=================================================

// Module: riscmakers_dcache_port_arbiter
// PURPOSE
//  Shares the single-transaction data cache among the PTW, load-unit and store-unit request ports.
//  Sits between the CPU request ports and the data cache, whose request port is one dcache_req_i_t
//  and which serves one transaction at a time.
//  Locks the cache to one owner from grant to completion and routes gnt/rvalid/rdata back to that owner only.
//  Fixed priority PTW > load > store, plus a starvation counter that promotes a waiting store.
// PARAMETERS
//  NUM_PORTS       3  requester count; index 0=PTW, 1=LOAD, 2=STORE (matches request_port_select_t)
//  STARVE_LIMIT    4  consecutive lost arbitrations after which a pending store wins the next arbitration
//  STARVE_CNT_W    3  width of starvation counter, >= $clog2(STARVE_LIMIT+1)
// PORTS
//  clk_i          in   1                 clock, rising edge
//  rst_i          in   1                 asynchronous reset, active high
//  req_ports_i    in   [NUM_PORTS] dcache_req_i_t   CPU-side requests
//  req_ports_o    out  [NUM_PORTS] dcache_req_o_t   CPU-side responses
//  cache_req_o    out  dcache_req_i_t    merged request to data cache
//  cache_req_i    in   dcache_req_o_t    data cache response (data_gnt, data_rvalid, data_rdata)
//  owner_o        out  2                 index of current owner; valid while busy_o
//  busy_o         out  1                 a transaction is locked to an owner
//  err_o          out  1                 sticky: data_rvalid received while no load/PTW awaited it
// BEHAVIOUR
//  Reset (async, takes effect immediately): state=IDLE, owner_q=0, starve_cnt=0, err_o=0.
//   All req_ports_o fields are 0, cache_req_o=0, busy_o=0, owner_o=0.
//  States:
//   IDLE: pick winner among data_req. Winner is STORE if store pending and starve_cnt==STARVE_LIMIT;
//    else PTW > LOAD > STORE. Register winner into owner_q.
//    Forward the winner's request combinationally to cache_req_o in the same cycle.
//    cache data_gnt -> winner data_gnt same cycle. Next state: gnt ? (store ? IDLE : WAIT_RVALID) : WAIT_GNT.
//   WAIT_GNT: owner_q is locked. Forward req_ports_i[owner_q] unchanged.
//    If owner drops data_req before gnt (kill), -> IDLE with no response.
//    On gnt: store -> IDLE; load/PTW -> WAIT_RVALID.
//   WAIT_RVALID: forward owner's address_tag, tag_valid and kill_req; data_req=0.
//    cache data_rvalid -> owner data_rvalid, with data_rdata, same cycle; -> IDLE.
//    kill_req does not end the state early; the cache is required to answer a kill with rvalid.
//  Latency: arbitration and all responses are combinational pass-through (0 added cycles).
//   After completion, at least 1 IDLE cycle precedes the next grant.
//  Isolation: non-owner req_ports_o are all-zero in every state. Non-owner requests wait ungranted.
//  Starvation counter:
//   +1 (saturating at STARVE_LIMIT) on each IDLE grant to PTW/LOAD while store data_req=1.
//   Cleared on a store grant, or when store data_req=0 in IDLE.
//  Simultaneous: cache gnt and rvalid in the same WAIT_GNT cycle -> gnt honoured, rvalid sets err_o.
//   A load and a store requesting in the same cycle: load wins unless the counter is saturated.
//  Stray rvalid in IDLE/WAIT_GNT: not forwarded, err_o<=1. err_o clears only on reset.
//  Reset mid-transaction drops ownership; a late cache rvalid after reset sets err_o.
//   Cache is reset on the same rst_i.
// STRUCTURE
//  dcache_pkg additions: arb_state_t {ARB_IDLE, ARB_WAIT_GNT, ARB_WAIT_RVALID};
//   localparam DCACHE_ARB_STARVE_LIMIT.
//  Port indices reuse PTW_PORT/LOAD_UNIT_PORT/STORE_UNIT_PORT.
//  Sub-module riscmakers_prio_starve_arb: request vector + starve flag -> one-hot winner.
//   Combinational, reusable for the icache refill mux.
//  Top contains the FSM, owner register, starvation counter, err flag and response demux.
// TESTING
//  1. Single load, cache gnt at cycle 0, rvalid at cycle 3 with rdata=0xDEADBEEF ->
//     load sees gnt c0, rvalid+0xDEADBEEF c3; store/PTW outputs stay 0.
//  2. Load and store requesting together, gnt delayed 2 cycles -> load owns (owner_o=1) from c0;
//     store ungranted until load rvalid, then granted after 1 IDLE cycle.
//  3. Load held continuously while store waits, STARVE_LIMIT=4 -> loads win 4 arbitrations,
//     store wins the 5th, starve_cnt returns to 0.
//  4. Load granted, kill_req=1 in WAIT_RVALID, cache rvalid 1 cycle later ->
//     kill forwarded downstream, rvalid routed to load, FSM back to IDLE, err_o=0.
//  5. rvalid pulse in IDLE -> no req_ports_o change, err_o=1 and sticky.
//     rst_i pulse mid WAIT_RVALID -> outputs 0 immediately, state IDLE.
//  6. PTW and load requesting together -> PTW granted first (owner_o=0), load granted next.

Source files
------------

// File: rtl/riscmakers_dcache_port_arbiter_pkg.sv
// rtl/riscmakers_dcache_port_arbiter_pkg.sv - data cache request/response types and arbiter definitions
package riscmakers_dcache_port_arbiter_pkg;

  localparam int unsigned DCACHE_ARB_STARVE_LIMIT = 4;

  localparam int unsigned PTW_PORT        = 0;
  localparam int unsigned LOAD_UNIT_PORT  = 1;
  localparam int unsigned STORE_UNIT_PORT = 2;

  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_GNT,
    ARB_WAIT_RVALID
  } arb_state_t;

endpackage

// File: rtl/riscmakers_prio_starve_arb.sv
// rtl/riscmakers_prio_starve_arb.sv - fixed-priority one-hot arbiter with a starvation promote input
module riscmakers_prio_starve_arb #(
  parameter int unsigned N           = 3,
  parameter int unsigned PROMOTE_IDX = N - 1
) (
  input  logic [N-1:0] req_i,
  input  logic         starve_i,
  output logic [N-1:0] gnt_o
);

  // Lowest index has priority; a starved PROMOTE_IDX requester overrides it.
  always_comb begin
    gnt_o = '0;
    if (starve_i && req_i[PROMOTE_IDX]) begin
      gnt_o[PROMOTE_IDX] = 1'b1;
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscmakers_dcache_port_arbiter.sv
// rtl/riscmakers_dcache_port_arbiter.sv - locks the single-transaction data cache to one of PTW/load/store
module riscmakers_dcache_port_arbiter
  import riscmakers_dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned STARVE_LIMIT = DCACHE_ARB_STARVE_LIMIT,
  parameter int unsigned STARVE_CNT_W = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t req_ports_i [NUM_PORTS],
  output dcache_req_o_t req_ports_o [NUM_PORTS],
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_req_i,
  output logic [1:0]    owner_o,
  output logic          busy_o,
  output logic          err_o
);

  arb_state_t              state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    err_q, err_d;

  logic [NUM_PORTS-1:0]    req_vec;
  logic [NUM_PORTS-1:0]    win_oh;
  logic [1:0]              win_idx;
  logic                    any_req;
  logic                    store_req;
  logic                    starve;
  dcache_req_i_t           owner_req;

  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      req_vec[i] = req_ports_i[i].data_req;
    end
  end

  assign any_req   = |req_vec;
  assign store_req = req_vec[STORE_UNIT_PORT];
  assign starve    = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
  assign owner_req = req_ports_i[owner_q];

  riscmakers_prio_starve_arb #(
    .N           (NUM_PORTS),
    .PROMOTE_IDX (STORE_UNIT_PORT)
  ) u_arb (
    .req_i    (req_vec),
    .starve_i (starve),
    .gnt_o    (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (win_oh[i]) win_idx = 2'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    cache_req_o  = '0;
    owner_o      = owner_q;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      req_ports_o[i] = '0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (cache_req_i.data_rvalid) err_d = 1'b1;
        if (!store_req) starve_cnt_d = '0;
        if (any_req) begin
          owner_d     = win_idx;
          owner_o     = win_idx;
          cache_req_o = req_ports_i[win_idx];
          req_ports_o[win_idx].data_gnt = cache_req_i.data_gnt;
          if (win_idx == 2'(STORE_UNIT_PORT)) begin
            starve_cnt_d = '0;
          end else if (store_req && !starve) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          if (cache_req_i.data_gnt) begin
            state_d = (win_idx == 2'(STORE_UNIT_PORT)) ? ARB_IDLE : ARB_WAIT_RVALID;
          end else begin
            state_d = ARB_WAIT_GNT;
          end
        end
      end
      ARB_WAIT_GNT: begin
        if (cache_req_i.data_rvalid) err_d = 1'b1;
        cache_req_o = owner_req;
        if (!owner_req.data_req) begin
          state_d = ARB_IDLE;
        end else if (cache_req_i.data_gnt) begin
          req_ports_o[owner_q].data_gnt = 1'b1;
          state_d = (owner_q == 2'(STORE_UNIT_PORT)) ? ARB_IDLE : ARB_WAIT_RVALID;
        end
      end
      ARB_WAIT_RVALID: begin
        // Only the tag phase continues; a kill still has to be answered by rvalid.
        cache_req_o.address_tag = owner_req.address_tag;
        cache_req_o.tag_valid   = owner_req.tag_valid;
        cache_req_o.kill_req    = owner_req.kill_req;
        if (cache_req_i.data_rvalid) begin
          req_ports_o[owner_q].data_rvalid = 1'b1;
          req_ports_o[owner_q].data_rdata  = cache_req_i.data_rdata;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (rst_i) begin
      cache_req_o = '0;
      owner_o     = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        req_ports_o[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  assign busy_o = (state_q != ARB_IDLE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_riscmakers_dcache_port_arbiter.sv
// tb/tb_riscmakers_dcache_port_arbiter.sv - vector and scoreboard bench for the dcache port arbiter
module tb_riscmakers_dcache_port_arbiter;
  import riscmakers_dcache_port_arbiter_pkg::*;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        kill;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic        e_creq;
    logic [1:0]  e_tport;
    logic        e_kill;
    logic [1:0]  e_owner;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  dcache_req_i_t req_ports_i [3];
  dcache_req_o_t req_ports_o [3];
  dcache_req_i_t cache_req_o;
  dcache_req_o_t cache_req_i;
  logic [1:0]    owner_o;
  logic          busy_o;
  logic          err_o;

  int   tests = 0;
  int   fails = 0;
  int   row   = 0;
  vec_t tbl [$];
  vec_t sb  [$];

  riscmakers_dcache_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_ports_i (req_ports_i),
    .req_ports_o (req_ports_o),
    .cache_req_o (cache_req_o),
    .cache_req_i (cache_req_i),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic [2:0] rq, logic k, logic g, logic rv, logic [31:0] rd,
                             logic [2:0] eg, logic [2:0] erv, logic ec, logic [1:0] et, logic ek,
                             logic [1:0] eo, logic eb, logic ee);
    vec_t t;
    t.rst = r; t.req = rq; t.kill = k; t.gnt = g; t.rv = rv; t.rdata = rd;
    t.e_gnt = eg; t.e_rv = erv; t.e_creq = ec; t.e_tport = et; t.e_kill = ek;
    t.e_owner = eo; t.e_busy = eb; t.e_err = ee;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic check();
    vec_t          e;
    dcache_req_o_t exp_o;
    logic [19:0]   exp_tag;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard row %0d: got empty expected entry", row);
      return;
    end
    e = sb.pop_front();
    for (int p = 0; p < 3; p++) begin
      exp_o.data_gnt    = e.e_gnt[p];
      exp_o.data_rvalid = e.e_rv[p];
      exp_o.data_rdata  = e.e_rv[p] ? e.rdata : 32'h0;
      cmp($sformatf("resp%0d", p), 64'(req_ports_o[p]), 64'(exp_o));
    end
    exp_tag = (e.e_tport == 2'd3) ? 20'h0 : 20'(32'h100 + 32'(e.e_tport));
    cmp("cache_req", 64'(cache_req_o.data_req), 64'(e.e_creq));
    cmp("cache_tag", 64'(cache_req_o.address_tag), 64'(exp_tag));
    cmp("cache_kill", 64'(cache_req_o.kill_req), 64'(e.e_kill));
    if (e.e_owner != 2'd3) cmp("owner", 64'(owner_o), 64'(e.e_owner));
    cmp("busy", 64'(busy_o), 64'(e.e_busy));
    cmp("err", 64'(err_o), 64'(e.e_err));
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst;
    for (int p = 0; p < 3; p++) begin
      req_ports_i[p]               = '0;
      req_ports_i[p].address_tag   = 20'(32'h100 + 32'(p));
      req_ports_i[p].address_index = 12'(p + 1);
      req_ports_i[p].data_req      = t.req[p];
      req_ports_i[p].data_we       = (p == 2);
    end
    req_ports_i[1].kill_req = t.kill;
    cache_req_i.data_gnt    = t.gnt;
    cache_req_i.data_rvalid = t.rv;
    cache_req_i.data_rdata  = t.rdata;
  endtask

  task automatic step(input vec_t t);
    @(posedge clk);
    #1;
    drive(t);
    sb.push_back(t);
    #4;
    check();
    row++;
  endtask

  initial begin
    vec_t idle;
    idle = v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 3, 0, 0);
    drive(v(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 0, 0, 0));

    // reset holds every output at zero even with a granted request present
    tbl.push_back(v(1, 3'b010, 0, 1, 0, 0, 3'b000, 3'b000, 0, 3, 0, 0, 0, 0));
    tbl.push_back(v(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 0, 0, 0));
    // single load, gnt c0, rvalid c3
    tbl.push_back(v(0, 3'b010, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b000, 0, 0, 1, 32'hDEADBEEF, 3'b000, 3'b010, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle);
    // load+store, gnt delayed 2 cycles; store waits then wins in IDLE
    tbl.push_back(v(0, 3'b110, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 3'b110, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b110, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b100, 0, 0, 1, 32'h12345678, 3'b000, 3'b010, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 3'b100, 0, 1, 0, 0, 3'b100, 3'b000, 1, 2, 0, 2, 0, 0));
    tbl.push_back(idle);
    // starvation: four load wins, then the store is promoted, then load wins again
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(v(0, 3'b110, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 0));
      tbl.push_back(v(0, 3'b110, 0, 0, 1, 32'(k + 16), 3'b000, 3'b010, 0, 1, 0, 1, 1, 0));
    end
    tbl.push_back(v(0, 3'b110, 0, 1, 0, 0, 3'b100, 3'b000, 1, 2, 0, 2, 0, 0));
    tbl.push_back(v(0, 3'b110, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 3'b000, 0, 0, 1, 32'h55, 3'b000, 3'b010, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle);
    // PTW beats load, load follows
    tbl.push_back(v(0, 3'b011, 0, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 3'b010, 0, 0, 1, 32'hA5A5A5A5, 3'b000, 3'b001, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 3'b010, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 3'b000, 0, 0, 1, 32'h00000BAD, 3'b000, 3'b010, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // kill in WAIT_RVALID is forwarded and still answered
    step(v(0, 3'b010, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 0));
    step(v(0, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 1, 0));
    step(v(0, 3'b000, 1, 0, 1, 32'h0000CAFE, 3'b000, 3'b010, 0, 1, 1, 1, 1, 0));
    step(idle);
    // request dropped in WAIT_GNT ends the lock silently
    step(v(0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 1, 0, 0));
    step(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 1, 1, 0));
    step(v(0, 3'b001, 0, 1, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0, 0));
    step(v(0, 3'b000, 0, 0, 1, 32'h1, 3'b000, 3'b001, 0, 0, 0, 0, 1, 0));
    // gnt and rvalid together in WAIT_GNT
    step(v(0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 1, 0, 0));
    step(v(0, 3'b010, 0, 1, 1, 32'h77, 3'b010, 3'b000, 1, 1, 0, 1, 1, 0));
    step(v(0, 3'b000, 0, 0, 1, 32'h88, 3'b000, 3'b010, 0, 1, 0, 1, 1, 1));
    step(v(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 0, 0, 0));
    // stray rvalid in IDLE sets a sticky error
    step(v(0, 3'b000, 0, 0, 1, 32'h99, 3'b000, 3'b000, 0, 3, 0, 3, 0, 0));
    step(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 3, 0, 1));
    step(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 3, 0, 1));
    // reset mid WAIT_RVALID, then a late rvalid
    step(v(0, 3'b010, 0, 1, 0, 0, 3'b010, 3'b000, 1, 1, 0, 1, 0, 1));
    step(v(1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 0, 0, 0));
    step(v(0, 3'b000, 0, 0, 1, 32'h42, 3'b000, 3'b000, 0, 3, 0, 3, 0, 0));
    step(v(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 3, 0, 3, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
